// File: rtl/decode_stage.sv
// decode_stage: register file, R/I-type decode and ID/EX pipeline register feeding the ALU
module decode_stage #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] ex_store_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_illegal
);
  localparam logic [3:0] AND = 4'b0000, OR = 4'b0001, ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110, SLT = 4'b0111, NOR = 4'b1100;
  logic [31:0] rf [NREG];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, sext, zext;
  logic [31:0] d_reg2, d_imm;
  logic [3:0]  d_ctrl;
  logic [4:0]  d_dest;
  logic        d_rw, d_mr, d_mw, d_br, d_ill;
  logic        wb_hit;
  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign sext   = {{16{imm[15]}}, imm};
  assign zext   = {16'h0, imm};
  assign wb_hit = wb_en && wb_addr != 5'd0;
  assign rs_val = (wb_hit && wb_addr == rs) ? wb_data : (rs == 5'd0 ? 32'h0 : rf[rs]);
  assign rt_val = (wb_hit && wb_addr == rt) ? wb_data : (rt == 5'd0 ? 32'h0 : rf[rt]);
  // register file: whole-array clear on reset, writes to r0 dropped
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    else if (wb_hit)
      rf[wb_addr] <= wb_data;
  // instruction decode; anything unmatched falls through as illegal with ADD and no side effects
  always_comb begin
    d_reg2 = rt_val;
    d_imm  = sext;
    d_ctrl = ADD;
    d_dest = 5'd0;
    d_rw   = 1'b0;
    d_mr   = 1'b0;
    d_mw   = 1'b0;
    d_br   = 1'b0;
    d_ill  = 1'b0;
    case (op)
      6'h00: begin
        d_dest = rd;
        d_rw   = 1'b1;
        case (funct)
          6'h20: d_ctrl = ADD;
          6'h22: d_ctrl = SUB;
          6'h24: d_ctrl = AND;
          6'h25: d_ctrl = OR;
          6'h27: d_ctrl = NOR;
          6'h2A: d_ctrl = SLT;
          default: begin
            d_ill  = 1'b1;
            d_dest = 5'd0;
            d_rw   = 1'b0;
          end
        endcase
      end
      6'h08: begin d_reg2 = sext; d_dest = rt; d_rw = 1'b1; end
      6'h0A: begin d_reg2 = sext; d_dest = rt; d_rw = 1'b1; d_ctrl = SLT; end
      6'h0C: begin d_reg2 = zext; d_imm = zext; d_dest = rt; d_rw = 1'b1; d_ctrl = AND; end
      6'h0D: begin d_reg2 = zext; d_imm = zext; d_dest = rt; d_rw = 1'b1; d_ctrl = OR; end
      6'h23: begin d_reg2 = sext; d_dest = rt; d_rw = 1'b1; d_mr = 1'b1; end
      6'h2B: begin d_reg2 = sext; d_mw = 1'b1; end
      6'h04: begin d_ctrl = SUB; d_br = 1'b1; end
      default: d_ill = 1'b1;
    endcase
  end
  // ID/EX register: reset and flush beat stall; an idle input slot loads a bubble
  always_ff @(posedge clk)
    if (reset || flush || (!stall && !in_valid))
      {ex_valid, reg1, reg2, alu_ctrl, ex_store_data, ex_imm, ex_dest,
       ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal} <= '0;
    else if (!stall)
      {ex_valid, reg1, reg2, alu_ctrl, ex_store_data, ex_imm, ex_dest,
       ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal} <=
      {1'b1, rs_val, d_reg2, d_ctrl, rt_val, d_imm, d_dest,
       d_rw, d_mr, d_mw, d_br, d_ill};
endmodule
